// File: rtl/spi_reg_bank.sv
// SPI slave register bank (mode 0) oversampled in the I_clk domain.
// Frame: R/W bit, ADDR_SIZE address bits, then DATA_SIZE-bit words until CSB rises.
module spi_reg_bank #(
    parameter int                   ADDR_SIZE = 8,
    parameter int                   DATA_SIZE = 8,
    parameter int                   NUM_REGS  = 4,
    parameter int                   NUM_STAT  = 2,
    parameter logic [DATA_SIZE-1:0] RST_VAL   = '0,
    parameter bit                   AUTO_INC  = 1'b1
) (
    input  logic                          I_clk,
    input  logic                          _I_rst,
    input  logic                          I_sclk,
    input  logic                          _I_csb,
    input  logic                          I_sdi,
    output logic                          O_sdo,
    output logic                          O_sdo_oe,
    input  logic [NUM_STAT*DATA_SIZE-1:0] I_status,
    output logic [NUM_REGS*DATA_SIZE-1:0] O_regs,
    output logic                          O_wr_stb,
    output logic [ADDR_SIZE-1:0]          O_wr_addr,
    output logic [DATA_SIZE-1:0]          O_wr_data
);

    localparam int CW = 6;

    typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

    state_t               state, state_nxt;
    logic                 sclk_s1, sclk_s2, sclk_s3;
    logic                 csb_s1, csb_s2;
    logic                 sdi_s1, sdi_s2;
    logic                 sclk_rise, sclk_fall;
    logic                 rw;
    logic [ADDR_SIZE-1:0] addr, addr_shift, addr_step, rd_addr;
    logic [DATA_SIZE-1:0] din, din_shift, dout_sh, rd_word;
    logic [CW-1:0]        cnt;
    logic                 last_addr, last_data, wr_hit;
    logic                 sdo_q;
    logic [DATA_SIZE-1:0] regs [NUM_REGS];

    assign sclk_rise  = sclk_s2 & ~sclk_s3;
    assign sclk_fall  = ~sclk_s2 & sclk_s3;
    assign addr_shift = ADDR_SIZE'({addr, sdi_s2});
    assign din_shift  = DATA_SIZE'({din, sdi_s2});
    assign addr_step  = AUTO_INC ? addr + 1'b1 : addr;
    assign last_addr  = (cnt == CW'(ADDR_SIZE - 1));
    assign last_data  = (cnt == CW'(DATA_SIZE - 1));
    assign wr_hit     = (32'(addr) < NUM_REGS);
    assign O_sdo_oe   = (state == DATA) && rw && !csb_s2;
    assign O_sdo      = sdo_q & O_sdo_oe;

    // Two-flop synchronisers plus an extra SCLK stage for edge detection
    always_ff @(posedge I_clk or negedge _I_rst) begin
        if (!_I_rst) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            csb_s1  <= 1'b1; csb_s2  <= 1'b1;
            sdi_s1  <= 1'b0; sdi_s2  <= 1'b0;
        end else begin
            sclk_s1 <= I_sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            csb_s1  <= _I_csb; csb_s2  <= csb_s1;
            sdi_s1  <= I_sdi;  sdi_s2  <= sdi_s1;
        end
    end

    // State register
    always_ff @(posedge I_clk or negedge _I_rst) begin
        if (!_I_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; CSB high returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (csb_s2) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CMD;
                CMD:     if (sclk_rise) state_nxt = ADDR;
                ADDR:    if (sclk_rise && last_addr) state_nxt = DATA;
                default: state_nxt = state;
            endcase
        end
    end

    // Read source: address being completed in ADDR, next streamed address in DATA
    always_comb begin
        rd_addr = (state == ADDR) ? addr_shift : addr_step;
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            if (32'(rd_addr) == k) rd_word = regs[k];
        for (int unsigned k = 0; k < NUM_STAT; k++)
            if (32'(rd_addr) == NUM_REGS + k) rd_word = I_status[k*DATA_SIZE +: DATA_SIZE];
    end

    // Shifting, register commit, write strobe and SDO serialisation
    always_ff @(posedge I_clk or negedge _I_rst) begin
        if (!_I_rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
            rw        <= 1'b0;
            addr      <= '0;
            din       <= '0;
            dout_sh   <= '0;
            cnt       <= '0;
            sdo_q     <= 1'b0;
            O_wr_stb  <= 1'b0;
            O_wr_addr <= '0;
            O_wr_data <= '0;
        end else begin
            O_wr_stb <= 1'b0;
            if (csb_s2) begin
                cnt   <= '0;
                sdo_q <= 1'b0;
            end else begin
                case (state)
                    CMD: if (sclk_rise) begin
                        rw  <= sdi_s2;
                        cnt <= '0;
                    end
                    ADDR: if (sclk_rise) begin
                        addr <= addr_shift;
                        if (last_addr) begin
                            cnt <= '0;
                            if (rw) dout_sh <= rd_word;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            din <= din_shift;
                            if (last_data) begin
                                cnt  <= '0;
                                addr <= addr_step;
                                if (rw) begin
                                    dout_sh <= rd_word;
                                end else if (wr_hit) begin
                                    for (int unsigned k = 0; k < NUM_REGS; k++)
                                        if (32'(addr) == k) regs[k] <= din_shift;
                                    O_wr_stb  <= 1'b1;
                                    O_wr_addr <= addr;
                                    O_wr_data <= din_shift;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (sclk_fall && rw) begin
                            sdo_q   <= dout_sh[DATA_SIZE-1];
                            dout_sh <= dout_sh << 1;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    // Flatten control registers onto the output bus
    always_comb begin
        O_regs = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++)
            O_regs[k*DATA_SIZE +: DATA_SIZE] = regs[k];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench: one auto-increment instance and one fixed-address instance.
`define CHECK(tag, obs, exp) \
    begin \
        n_cmp++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %h expected %h", tag, obs, exp); \
        end \
    end

module tb_spi_reg_bank;

    logic        clk, rst_n, sclk, sdi, csb_a, csb_b;
    logic [15:0] status;
    logic        sdo_a, oe_a, stb_a, sdo_b, oe_b, stb_b;
    logic [31:0] regs_a, regs_b;
    logic [7:0]  wa_a, wd_a, wa_b, wd_b;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  tx [8];
    logic [7:0]  rx [8];
    logic [7:0]  m  [2][4];
    logic [15:0] got_a[$], got_b[$];

    spi_reg_bank #(.AUTO_INC(1'b1)) u_a (
        .I_clk(clk), ._I_rst(rst_n), .I_sclk(sclk), ._I_csb(csb_a), .I_sdi(sdi),
        .O_sdo(sdo_a), .O_sdo_oe(oe_a), .I_status(status), .O_regs(regs_a),
        .O_wr_stb(stb_a), .O_wr_addr(wa_a), .O_wr_data(wd_a)
    );

    spi_reg_bank #(.AUTO_INC(1'b0)) u_b (
        .I_clk(clk), ._I_rst(rst_n), .I_sclk(sclk), ._I_csb(csb_b), .I_sdi(sdi),
        .O_sdo(sdo_b), .O_sdo_oe(oe_b), .I_status(status), .O_regs(regs_b),
        .O_wr_stb(stb_b), .O_wr_addr(wa_b), .O_wr_data(wd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe with its address/data, sampled mid-cycle
    always @(negedge clk) begin
        if (stb_a) got_a.push_back({wa_a, wd_a});
        if (stb_b) got_b.push_back({wa_b, wd_b});
    end

    function automatic logic [7:0] model_read(input int d, input int a);
        if (a < 4)      return m[d][a];
        else if (a < 6) return status[(a-4)*8 +: 8];
        else            return 8'h00;
    endfunction

    task automatic send_bit(input int d, input bit b, output bit sdo_v, output bit oe_v);
        sdi = b;
        #50;
        sdo_v = (d == 0) ? sdo_a : sdo_b;
        oe_v  = (d == 0) ? oe_a : oe_b;
        sclk  = 1'b1;
        #50;
        sclk  = 1'b0;
    endtask

    task automatic run_frame(input int d, input bit rw, input logic [7:0] addr,
                             input int nw, input int partial);
        bit         s, o;
        int         oe_err;
        logic [7:0] w;
        oe_err = 0;
        got_a.delete();
        got_b.delete();
        if (d == 0) csb_a = 1'b0; else csb_b = 1'b0;
        #100;
        send_bit(d, rw, s, o);
        if (o) oe_err++;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d, addr[i], s, o);
            if (o) oe_err++;
        end
        for (int wi = 0; wi < nw; wi++) begin
            w = tx[wi];
            for (int b = 7; b >= 0; b--) begin
                send_bit(d, w[b], s, o);
                if (o !== rw) oe_err++;
                rx[wi][b] = s;
            end
        end
        for (int p = 0; p < partial; p++) begin
            send_bit(d, 1'($urandom), s, o);
            if (o !== rw) oe_err++;
        end
        #100;
        if (d == 0) csb_a = 1'b1; else csb_b = 1'b1;
        #100;
        o = (d == 0) ? oe_a : oe_b;
        if (o) oe_err++;
        `CHECK("oe_window", oe_err, 0)
    endtask

    task automatic check_frame(input int d, input bit rw, input logic [7:0] addr,
                               input int nw, input string tag);
        logic [15:0] exp_q[$];
        logic [15:0] got[$];
        logic [31:0] exp_regs;
        int          a;
        for (int wi = 0; wi < nw; wi++) begin
            a = (d == 0) ? ((int'(addr) + wi) % 256) : int'(addr);
            if (rw) begin
                `CHECK({tag, "_rd"}, rx[wi], model_read(d, a))
            end else if (a < 4) begin
                m[d][a] = tx[wi];
                exp_q.push_back({8'(a), tx[wi]});
            end
        end
        if (d == 0) got = got_a; else got = got_b;
        `CHECK({tag, "_stb_count"}, got.size(), exp_q.size())
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            `CHECK({tag, "_stb_entry"}, got[i], exp_q[i])
        if (exp_q.size() > 0) begin
            if (d == 0) `CHECK({tag, "_wr_hold"}, {wa_a, wd_a}, exp_q[$])
            else        `CHECK({tag, "_wr_hold"}, {wa_b, wd_b}, exp_q[$])
        end
        for (int k = 0; k < 4; k++) exp_regs[k*8 +: 8] = m[d][k];
        if (d == 0) `CHECK({tag, "_regs"}, regs_a, exp_regs)
        else        `CHECK({tag, "_regs"}, regs_b, exp_regs)
    endtask

    initial begin
        bit         s, o;
        int         d, nw, pick;
        bit         rw;
        logic [7:0] addr;

        rst_n = 1'b0; sclk = 1'b0; sdi = 1'b0; csb_a = 1'b1; csb_b = 1'b1;
        status = 16'h0000;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) m[i][k] = 8'h00;
        #100;
        rst_n = 1'b1;
        #100;

        // Reset state
        `CHECK("rst_regs_a", regs_a, 32'h0)
        `CHECK("rst_regs_b", regs_b, 32'h0)
        `CHECK("rst_oe", oe_a, 1'b0)
        `CHECK("rst_sdo", sdo_a, 1'b0)
        `CHECK("rst_stb", stb_a, 1'b0)
        `CHECK("rst_wr", {wa_a, wd_a}, 16'h0)

        // Single write
        tx[0] = 8'hA5;
        run_frame(0, 1'b0, 8'h02, 1, 0);
        check_frame(0, 1'b0, 8'h02, 1, "single_wr");
        `CHECK("single_wr_field", regs_a[23:16], 8'hA5)

        // Streaming write running into the status range
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'h44; tx[4] = 8'h55;
        run_frame(0, 1'b0, 8'h00, 5, 0);
        check_frame(0, 1'b0, 8'h00, 5, "stream_wr");

        // Status read
        status = {8'hBE, 8'hEF};
        run_frame(0, 1'b1, 8'h04, 2, 0);
        check_frame(0, 1'b1, 8'h04, 2, "stat_rd");
        `CHECK("stat_rd_w0", rx[0], 8'hEF)
        `CHECK("stat_rd_w1", rx[1], 8'hBE)

        // Abort mid-word, then a full frame to the same address
        run_frame(0, 1'b0, 8'h01, 0, 5);
        check_frame(0, 1'b0, 8'h01, 0, "abort");
        tx[0] = 8'h7E;
        run_frame(0, 1'b0, 8'h01, 1, 0);
        check_frame(0, 1'b0, 8'h01, 1, "after_abort");

        // Address wrap: 0xFF unmapped, then 0x00 and 0x01
        tx[0] = 8'h9C; tx[1] = 8'h3D; tx[2] = 8'hE1;
        run_frame(0, 1'b0, 8'hFF, 3, 0);
        check_frame(0, 1'b0, 8'hFF, 3, "wrap_wr");

        // Fixed-address instance
        tx[0] = 8'h01; tx[1] = 8'h02;
        run_frame(1, 1'b0, 8'h03, 2, 0);
        check_frame(1, 1'b0, 8'h03, 2, "noinc_wr");
        run_frame(1, 1'b1, 8'h03, 2, 0);
        check_frame(1, 1'b1, 8'h03, 2, "noinc_rd");

        // Reset in the middle of a write frame
        got_a.delete();
        csb_a = 1'b0;
        #100;
        send_bit(0, 1'b0, s, o);
        for (int i = 7; i >= 0; i--) send_bit(0, (i == 1), s, o);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, s, o);
        rst_n = 1'b0;
        #30;
        `CHECK("midrst_regs_a", regs_a, 32'h0)
        `CHECK("midrst_regs_b", regs_b, 32'h0)
        `CHECK("midrst_oe", oe_a, 1'b0)
        `CHECK("midrst_stb", got_a.size(), 0)
        `CHECK("midrst_wr", {wa_a, wd_a}, 16'h0)
        csb_a = 1'b1;
        #20;
        rst_n = 1'b1;
        #200;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) m[i][k] = 8'h00;
        tx[0] = 8'hC3;
        run_frame(0, 1'b0, 8'h02, 1, 0);
        check_frame(0, 1'b0, 8'h02, 1, "post_rst_wr");

        // Randomised frames against the model
        for (int f = 0; f < 40; f++) begin
            d    = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rw   = 1'($urandom);
            pick = $urandom_range(0, 9);
            addr = (pick < 8) ? 8'(pick) : ((pick == 8) ? 8'hFE : 8'hFF);
            nw   = $urandom_range(1, 4);
            status = 16'($urandom);
            for (int i = 0; i < nw; i++) tx[i] = 8'($urandom);
            run_frame(d, rw, addr, nw, 0);
            check_frame(d, rw, addr, nw, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
